pc_sequencer: RTL and testbench

//  Control sequencer that drives the program_counter vector/offset/jump inputs each cycle.

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the PC sequencer.
// The state encoding is fixed at 3 bits so that unused codes exist and can be recovered.
package pc_seq_pkg;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_LANES        = 4;
  localparam int DEF_LANE_W       = 2;
  localparam int DEF_FLUSH_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SCALAR = 3'd2,
    FLUSH  = 3'd3,
    HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Control sequencer that drives the program counter each cycle.
// It issues vector ops, walks scalar ops across lanes, redirects on taken branches, and handles stall and halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LANES        = DEF_LANES,
  parameter int LANE_W       = DEF_LANE_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic              instr_is_vector,
  input  logic              instr_is_branch,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              instr_is_halt,
  output logic              pc_vector,
  output logic [LANE_W-1:0] pc_offset,
  output logic              pc_jump_enable,
  output logic [ADDR_W-1:0] pc_jump_address,
  output logic              issue_valid,
  output logic              issue_all_lanes,
  output logic [LANE_W-1:0] issue_lane,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        instr_count
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
  logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]          instr_count_q, instr_count_d;

  always_comb begin
    state_d         = state_q;
    lane_cnt_d      = lane_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    instr_count_d   = instr_count_q;
    pc_vector       = 1'b0;
    pc_offset       = lane_cnt_q;
    pc_jump_enable  = 1'b0;
    pc_jump_address = '0;
    issue_valid     = 1'b0;
    issue_all_lanes = 1'b0;
    issue_lane      = '0;

    // A stall freezes everything; lane_cnt still reaches pc_offset so the datapath keeps its lane.
    if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          if (instr_valid) begin
            if (instr_is_halt) begin
              instr_count_d = instr_count_q + 8'd1;
              state_d       = HALTED;
            end else if (instr_is_branch && branch_taken) begin
              pc_jump_enable  = 1'b1;
              pc_jump_address = branch_target;
              instr_count_d   = instr_count_q + 8'd1;
              flush_cnt_d     = FLUSH_W'(FLUSH_CYCLES - 1);
              state_d         = FLUSH;
            end else if (instr_is_branch) begin
              pc_vector     = 1'b1;
              instr_count_d = instr_count_q + 8'd1;
            end else if (instr_is_vector) begin
              issue_valid     = 1'b1;
              issue_all_lanes = 1'b1;
              pc_vector       = 1'b1;
              instr_count_d   = instr_count_q + 8'd1;
            end else begin
              issue_valid = 1'b1;
              if (LANES == 1) begin
                pc_vector     = 1'b1;
                instr_count_d = instr_count_q + 8'd1;
              end else begin
                lane_cnt_d = LANE_W'(1);
                state_d    = SCALAR;
              end
            end
          end
        end
        SCALAR: begin
          issue_valid = 1'b1;
          issue_lane  = lane_cnt_q;
          if (lane_cnt_q == LANE_W'(LANES - 1)) begin
            pc_vector     = 1'b1;
            instr_count_d = instr_count_q + 8'd1;
            lane_cnt_d    = '0;
            state_d       = RUN;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0) state_d = RUN;
          else                   flush_cnt_d = flush_cnt_q - 1'b1;
        end
        HALTED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE) && (state_q != HALTED);
    halted      = (state_q == HALTED);
    instr_count = instr_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      lane_cnt_q    <= '0;
      flush_cnt_q   <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// Each cycle's expected output frame is queued as stimulus is driven, then popped and compared mid-cycle.
module tb_pc_sequencer;

  typedef struct packed {
    logic       pcv;
    logic [1:0] off;
    logic       je;
    logic [7:0] ja;
    logic       iv;
    logic       ial;
    logic [1:0] il;
    logic       busy;
    logic       halted;
    logic [7:0] cnt;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stall, instr_valid, instr_is_vector, instr_is_branch, branch_taken, instr_is_halt;
  logic [7:0] branch_target;
  logic       pc_vector, pc_jump_enable, issue_valid, issue_all_lanes, busy, halted;
  logic [1:0] pc_offset, issue_lane;
  logic [7:0] pc_jump_address, instr_count;

  frame_t sbq[$];
  int     compared   = 0;
  int     mismatched = 0;
  int     frame_no   = 0;
  int     exp_cnt    = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr_is_vector(instr_is_vector),
    .instr_is_branch(instr_is_branch),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instr_is_halt  (instr_is_halt),
    .pc_vector      (pc_vector),
    .pc_offset      (pc_offset),
    .pc_jump_enable (pc_jump_enable),
    .pc_jump_address(pc_jump_address),
    .issue_valid    (issue_valid),
    .issue_all_lanes(issue_all_lanes),
    .issue_lane     (issue_lane),
    .busy           (busy),
    .halted         (halted),
    .instr_count    (instr_count)
  );

  function automatic frame_t mk(input logic pcv, input logic [1:0] off, input logic je,
                                input logic [7:0] ja, input logic iv, input logic ial,
                                input logic [1:0] il, input logic bsy, input logic hlt,
                                input int cnt);
    frame_t f;
    f.pcv = pcv; f.off = off; f.je = je; f.ja = ja; f.iv = iv; f.ial = ial;
    f.il = il; f.busy = bsy; f.halted = hlt; f.cnt = cnt[7:0];
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (frame %0d): got %0h, expected %0h", tag, frame_no, obs, exp);
    end
  endtask

  task automatic setIn(input logic st, input logic sl, input logic v, input logic vec,
                       input logic br, input logic tk, input logic [7:0] tgt, input logic h);
    start = st; stall = sl; instr_valid = v; instr_is_vector = vec;
    instr_is_branch = br; branch_taken = tk; branch_target = tgt; instr_is_halt = h;
  endtask

  task automatic compareFrame();
    frame_t e;
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 8'd1, 8'd0);
      return;
    end
    e = sbq.pop_front();
    checkOutput("pc_vector",       {7'd0, pc_vector},       {7'd0, e.pcv});
    checkOutput("pc_offset",       {6'd0, pc_offset},       {6'd0, e.off});
    checkOutput("pc_jump_enable",  {7'd0, pc_jump_enable},  {7'd0, e.je});
    checkOutput("pc_jump_address", pc_jump_address,         e.ja);
    checkOutput("issue_valid",     {7'd0, issue_valid},     {7'd0, e.iv});
    checkOutput("issue_all_lanes", {7'd0, issue_all_lanes}, {7'd0, e.ial});
    checkOutput("issue_lane",      {6'd0, issue_lane},      {6'd0, e.il});
    checkOutput("busy",            {7'd0, busy},            {7'd0, e.busy});
    checkOutput("halted",          {7'd0, halted},          {7'd0, e.halted});
    checkOutput("instr_count",     instr_count,             e.cnt);
    frame_no++;
  endtask

  // Queue the expected frame, compare at the falling edge, then move to just past the next rising edge.
  task automatic applyStimulus(input frame_t e);
    sbq.push_back(e);
    @(negedge clk);
    compareFrame();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    #1;
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    setIn(1, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, exp_cnt));

    // Three back-to-back vector ops.
    for (int i = 0; i < 3; i++) begin
      setIn(0, 0, 1, 1, 0, 0, 8'h00, 0);
      applyStimulus(mk(1, 0, 0, 8'h00, 1, 1, 0, 1, 0, exp_cnt));
      exp_cnt++;
    end
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, exp_cnt));

    // Scalar op; a vector op waits on the decode inputs until the lane walk ends.
    setIn(0, 0, 1, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, exp_cnt));
    setIn(0, 0, 1, 1, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 1, 0, 8'h00, 1, 0, 1, 1, 0, exp_cnt));
    applyStimulus(mk(0, 2, 0, 8'h00, 1, 0, 2, 1, 0, exp_cnt));
    applyStimulus(mk(1, 3, 0, 8'h00, 1, 0, 3, 1, 0, exp_cnt));
    exp_cnt++;
    applyStimulus(mk(1, 0, 0, 8'h00, 1, 1, 0, 1, 0, exp_cnt));
    exp_cnt++;
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, exp_cnt));

    // Taken branch, one flush bubble ignoring a valid op, then a not-taken branch.
    setIn(0, 0, 1, 0, 1, 1, 8'h14, 0);
    applyStimulus(mk(0, 0, 1, 8'h14, 0, 0, 0, 1, 0, exp_cnt));
    exp_cnt++;
    setIn(0, 0, 1, 1, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, exp_cnt));
    setIn(0, 0, 1, 0, 1, 0, 8'h33, 0);
    applyStimulus(mk(1, 0, 0, 8'h00, 0, 0, 0, 1, 0, exp_cnt));
    exp_cnt++;

    // Scalar op stalled for three cycles at lane 2.
    setIn(0, 0, 1, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, exp_cnt));
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 1, 0, 8'h00, 1, 0, 1, 1, 0, exp_cnt));
    setIn(0, 1, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(0, 2, 0, 8'h00, 0, 0, 0, 1, 0, exp_cnt));
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 2, 0, 8'h00, 1, 0, 2, 1, 0, exp_cnt));
    applyStimulus(mk(1, 3, 0, 8'h00, 1, 0, 3, 1, 0, exp_cnt));
    exp_cnt++;
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, exp_cnt));

    // Halt wins over a taken branch; start and valid ops are ignored afterwards.
    setIn(0, 0, 1, 0, 1, 1, 8'h55, 1);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, exp_cnt));
    exp_cnt++;
    setIn(1, 0, 1, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++)
      applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, exp_cnt));

    // Reset out of HALTED, enter a scalar walk, then reset asynchronously between edges.
    reset = 1'b1;
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    exp_cnt = 0;
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, exp_cnt));
    reset = 1'b0;
    setIn(1, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, exp_cnt));
    setIn(0, 0, 1, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, exp_cnt));
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    #2;
    reset = 1'b1;
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, exp_cnt));
    reset = 1'b0;
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, exp_cnt));

    // 256 vector ops wrap the retired-instruction counter back to zero.
    setIn(1, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, exp_cnt));
    setIn(0, 0, 1, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(mk(1, 0, 0, 8'h00, 1, 1, 0, 1, 0, exp_cnt));
      exp_cnt = (exp_cnt + 1) % 256;
    end
    setIn(0, 0, 0, 0, 0, 0, 8'h00, 0);
    applyStimulus(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
